// File: rtl/alu_sys_pkg.sv
// Shared constants for the ALU command path: opcodes, error byte, widths,
// controller state encoding and ALU function codes.
// Pure declarations; no logic, no latency, no flow control.
package alu_sys_pkg;

    localparam int OPER_WIDTH = 8;
    localparam int OUT_WIDTH  = 2 * OPER_WIDTH;

    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;
    localparam logic [7:0] ERR_CODE    = 8'hEE;
    localparam logic [7:0] FUN_MAX     = 8'h0E;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_GET_A    = 4'd1,
        ST_GET_B    = 4'd2,
        ST_GET_FUN  = 4'd3,
        ST_ALU_RUN  = 4'd4,
        ST_ALU_WAIT = 4'd5,
        ST_SEND_LO  = 4'd6,
        ST_SEND_HI  = 4'd7,
        ST_SEND_ERR = 4'd8
    } ctrl_state_e;

    typedef enum logic [3:0] {
        FUN_ADD   = 4'h0,
        FUN_SUB   = 4'h1,
        FUN_MUL   = 4'h2,
        FUN_DIV   = 4'h3,
        FUN_AND   = 4'h4,
        FUN_OR    = 4'h5,
        FUN_NAND  = 4'h6,
        FUN_NOR   = 4'h7,
        FUN_XOR   = 4'h8,
        FUN_XNOR  = 4'h9,
        FUN_CMPEQ = 4'hA,
        FUN_CMPGT = 4'hB,
        FUN_CMPLT = 4'hC,
        FUN_SHR   = 4'hD,
        FUN_SHL   = 4'hE
    } alu_fun_e;

    // A function byte is usable only if it maps onto one of the codes above.
    function automatic logic fun_is_legal(input logic [7:0] b);
        return (b <= FUN_MAX);
    endfunction

endpackage

// File: rtl/alu_cmd_ctrl_if.sv
// Bundles the RX, ALU and TX side signals of the command controller.
// No logic, no latency.
// master = controller view; slave = the surrounding RX/ALU/TX blocks.
interface alu_cmd_ctrl_if;
    import alu_sys_pkg::*;

    logic [OPER_WIDTH-1:0] RX_P_DATA;
    logic                  RX_D_VLD;
    logic [OUT_WIDTH-1:0]  ALU_OUT;
    logic                  ALU_OUT_VLD;
    logic                  TX_BUSY;
    logic [OPER_WIDTH-1:0] ALU_A;
    logic [OPER_WIDTH-1:0] ALU_B;
    logic [3:0]            ALU_FUN;
    logic                  ALU_EN;
    logic [7:0]            TX_P_DATA;
    logic                  TX_D_VLD;
    logic                  CTRL_BUSY;
    logic                  TIMEOUT_ERR;

    modport master (
        input  RX_P_DATA, RX_D_VLD, ALU_OUT, ALU_OUT_VLD, TX_BUSY,
        output ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD,
               CTRL_BUSY, TIMEOUT_ERR
    );

    modport slave (
        output RX_P_DATA, RX_D_VLD, ALU_OUT, ALU_OUT_VLD, TX_BUSY,
        input  ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD,
               CTRL_BUSY, TIMEOUT_ERR
    );

endinterface

// File: rtl/alu_tx_serializer.sv
// Turns a captured 16-bit result into low-then-high TX bytes, or sends the error byte.
// Latency: byte valid the cycle after a load; next byte the cycle after each transfer.
// Backpressure: o_tx_vld/o_tx_data held while i_tx_busy is high; transfer = vld & !busy.
module alu_tx_serializer
    import alu_sys_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 i_load_res,
    input  logic [OUT_WIDTH-1:0] i_res,
    input  logic                 i_load_err,
    input  logic                 i_tx_busy,
    output logic [7:0]           o_tx_data,
    output logic                 o_tx_vld,
    output logic                 o_xfer
);

    logic [OUT_WIDTH-1:0] r_result;
    logic                 r_hi_pend;
    logic [7:0]           r_tx_data;
    logic                 r_tx_vld;
    logic                 w_xfer;

    assign w_xfer    = r_tx_vld & ~i_tx_busy;
    assign o_xfer    = w_xfer;
    assign o_tx_data = r_tx_data;
    assign o_tx_vld  = r_tx_vld;

    // Loads only arrive while idle, so they never collide with a pending byte.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_result  <= '0;
            r_hi_pend <= 1'b0;
            r_tx_data <= '0;
            r_tx_vld  <= 1'b0;
        end else if (i_load_res) begin
            r_result  <= i_res;
            r_tx_data <= i_res[7:0];
            r_tx_vld  <= 1'b1;
            r_hi_pend <= 1'b1;
        end else if (i_load_err) begin
            r_tx_data <= ERR_CODE;
            r_tx_vld  <= 1'b1;
            r_hi_pend <= 1'b0;
        end else if (w_xfer) begin
            if (r_hi_pend) begin
                r_tx_data <= r_result[15:8];
                r_hi_pend <= 1'b0;
            end else begin
                r_tx_vld  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Parses CC/DD command bytes, drives ALU operands/enable, returns the result as two TX bytes.
// Latency: ALU_EN one cycle after the function byte; first TX byte two cycles after ALU_EN.
// Backpressure: TX held under TX_BUSY; RX bytes outside the parse states are dropped.
module alu_cmd_ctrl
    import alu_sys_pkg::*;
#(
    parameter int ALU_TIMEOUT = 15
)
(
    input  logic           CLK,
    input  logic           RST,
    alu_cmd_ctrl_if.master bus
);

    localparam int                CNT_W    = $clog2(ALU_TIMEOUT + 1);
    // ALU_RUN clears the counter and the error flop adds a cycle, so stopping
    // two short of ALU_TIMEOUT lands the TIMEOUT_ERR pulse ALU_TIMEOUT cycles after ALU_EN.
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ALU_TIMEOUT - 2);

    ctrl_state_e          r_state;
    logic [7:0]           r_alu_a;
    logic [7:0]           r_alu_b;
    logic [3:0]           r_alu_fun;
    logic                 r_alu_en;
    logic                 r_busy;
    logic                 r_tmo_err;
    logic [CNT_W-1:0]     r_cnt;

    logic                 w_load_res;
    logic                 w_load_err;
    logic                 w_xfer;
    logic [7:0]           w_tx_data;
    logic                 w_tx_vld;

    assign w_load_res = (r_state == ST_ALU_WAIT) && bus.ALU_OUT_VLD;
    assign w_load_err = (r_state == ST_GET_FUN) && bus.RX_D_VLD && !fun_is_legal(bus.RX_P_DATA);

    // Command sequencer and ALU watchdog; every output is a flop.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_fun <= '0;
            r_alu_en  <= 1'b0;
            r_busy    <= 1'b0;
            r_tmo_err <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_alu_en  <= 1'b0;
            r_tmo_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.RX_D_VLD && bus.RX_P_DATA == CMD_ALU_OP) begin
                        r_state <= ST_GET_A;
                        r_busy  <= 1'b1;
                    end else if (bus.RX_D_VLD && bus.RX_P_DATA == CMD_ALU_NOP) begin
                        r_state <= ST_GET_FUN;
                        r_busy  <= 1'b1;
                    end
                end
                ST_GET_A: begin
                    if (bus.RX_D_VLD) begin
                        r_alu_a <= bus.RX_P_DATA;
                        r_state <= ST_GET_B;
                    end
                end
                ST_GET_B: begin
                    if (bus.RX_D_VLD) begin
                        r_alu_b <= bus.RX_P_DATA;
                        r_state <= ST_GET_FUN;
                    end
                end
                ST_GET_FUN: begin
                    if (bus.RX_D_VLD) begin
                        if (fun_is_legal(bus.RX_P_DATA)) begin
                            r_alu_fun <= bus.RX_P_DATA[3:0];
                            r_alu_en  <= 1'b1;
                            r_state   <= ST_ALU_RUN;
                        end else begin
                            r_state   <= ST_SEND_ERR;
                        end
                    end
                end
                ST_ALU_RUN: begin
                    r_cnt   <= '0;
                    r_state <= ST_ALU_WAIT;
                end
                ST_ALU_WAIT: begin
                    if (bus.ALU_OUT_VLD) begin
                        r_state <= ST_SEND_LO;
                    end else if (r_cnt == CNT_LAST) begin
                        r_tmo_err <= 1'b1;
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_SEND_LO: begin
                    if (w_xfer) r_state <= ST_SEND_HI;
                end
                ST_SEND_HI, ST_SEND_ERR: begin
                    if (w_xfer) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    alu_tx_serializer u_tx (
        .CLK        (CLK),
        .RST        (RST),
        .i_load_res (w_load_res),
        .i_res      (bus.ALU_OUT),
        .i_load_err (w_load_err),
        .i_tx_busy  (bus.TX_BUSY),
        .o_tx_data  (w_tx_data),
        .o_tx_vld   (w_tx_vld),
        .o_xfer     (w_xfer)
    );

    assign bus.ALU_A       = r_alu_a;
    assign bus.ALU_B       = r_alu_b;
    assign bus.ALU_FUN     = r_alu_fun;
    assign bus.ALU_EN      = r_alu_en;
    assign bus.CTRL_BUSY   = r_busy;
    assign bus.TIMEOUT_ERR = r_tmo_err;
    assign bus.TX_P_DATA   = w_tx_data;
    assign bus.TX_D_VLD    = w_tx_vld;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Bench for alu_cmd_ctrl: directed command cases followed by random command traffic.
// A stand-in ALU answers each ALU_EN one cycle later; a command-level model predicts TX bytes.
// TX_BUSY is driven both in fixed holds and randomly to exercise the TX handshake.
module tb_alu_cmd_ctrl;
    import alu_sys_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    alu_cmd_ctrl_if bus();

    alu_cmd_ctrl #(.ALU_TIMEOUT(15)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference ALU behaviour used both by the stand-in ALU and by the model.
    function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
        logic [15:0] x;
        logic [15:0] y;
        x = {8'h00, a};
        y = {8'h00, b};
        case (f)
            4'h0: return x + y;
            4'h1: return x - y;
            4'h2: return x * y;
            4'h3: return (b != 8'h00) ? x / y : 16'h0000;
            4'h4: return x & y;
            4'h5: return x | y;
            4'h6: return {8'h00, ~(a & b)};
            4'h7: return {8'h00, ~(a | b)};
            4'h8: return x ^ y;
            4'h9: return {8'h00, ~(a ^ b)};
            4'hA: return 16'(a == b);
            4'hB: return 16'(a > b);
            4'hC: return 16'(a < b);
            4'hD: return x >> 1;
            4'hE: return x << 1;
            default: return 16'h0000;
        endcase
    endfunction

    // ---------------- stand-in ALU ----------------
    bit alu_vld_ena = 1'b1;

    initial begin
        bus.ALU_OUT     = '0;
        bus.ALU_OUT_VLD = 1'b0;
        forever begin
            @(negedge CLK);
            if (bus.ALU_EN) begin
                @(posedge CLK); #1;
                bus.ALU_OUT     = alu_f(bus.ALU_A, bus.ALU_B, bus.ALU_FUN);
                bus.ALU_OUT_VLD = alu_vld_ena;
                @(posedge CLK); #1;
                bus.ALU_OUT_VLD = 1'b0;
            end
        end
    end

    // ---------------- output monitor ----------------
    logic [7:0] tx_q[$];
    int   en_cnt = 0, en_cyc = 0, tmo_cnt = 0, tmo_cyc = 0, rise_cyc = 0;
    logic prev_hold = 1'b0, prev_vld = 1'b0;
    logic [7:0] prev_dat = 8'h00;

    initial begin
        forever begin
            @(negedge CLK);
            if (RST) begin
                prev_hold = 1'b0;
                prev_vld  = 1'b0;
            end else begin
                if (prev_hold) begin
                    check("tx_hold_vld", 32'(bus.TX_D_VLD), 32'd1);
                    check("tx_hold_dat", 32'(bus.TX_P_DATA), 32'(prev_dat));
                end
                if (bus.ALU_EN) begin en_cnt++; en_cyc = cyc; end
                if (bus.TIMEOUT_ERR) begin tmo_cnt++; tmo_cyc = cyc; end
                if (bus.TX_D_VLD && !prev_vld) rise_cyc = cyc;
                if (bus.TX_D_VLD && !bus.TX_BUSY) tx_q.push_back(bus.TX_P_DATA);
                prev_hold = bus.TX_D_VLD && bus.TX_BUSY;
                prev_vld  = bus.TX_D_VLD;
                prev_dat  = bus.TX_P_DATA;
            end
        end
    end

    // ---------------- command-level model ----------------
    logic [7:0] ma = 8'h00, mb = 8'h00;
    logic [3:0] mfun = 4'h0;
    logic [7:0] exp_q[$];
    int   exp_en = 0, tx_base = 0, en_base = 0, tmo_base = 0;

    task automatic begin_cmd();
        tx_base  = tx_q.size();
        en_base  = en_cnt;
        tmo_base = tmo_cnt;
        exp_q.delete();
        exp_en   = 0;
    endtask

    task automatic model_cmd(input bit is_op, input logic [7:0] a, input logic [7:0] b, input logic [7:0] f);
        logic [15:0] r;
        if (is_op) begin ma = a; mb = b; end
        if (f <= 8'h0E) begin
            mfun = f[3:0];
            r = alu_f(ma, mb, mfun);
            exp_q.push_back(r[7:0]);
            exp_q.push_back(r[15:8]);
            exp_en = 1;
        end else begin
            exp_q.push_back(ERR_CODE);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge CLK); #1;
        bus.RX_P_DATA = b;
        bus.RX_D_VLD  = 1'b1;
        @(posedge CLK); #1;
        bus.RX_D_VLD  = 1'b0;
    endtask

    task automatic send_cmd(input bit is_op, input logic [7:0] a, input logic [7:0] b, input logic [7:0] f);
        send_byte(is_op ? CMD_ALU_OP : CMD_ALU_NOP);
        if (is_op) begin send_byte(a); send_byte(b); end
        send_byte(f);
    endtask

    task automatic wait_idle(input bit rnd_busy);
        bit done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge CLK); #1;
            if (rnd_busy) bus.TX_BUSY = 1'($urandom_range(0, 1));
            @(negedge CLK);
            if (!bus.CTRL_BUSY) begin done = 1'b1; break; end
        end
        check("idle_reached", 32'(done), 32'd1);
    endtask

    task automatic wait_tx_vld();
        bit seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (bus.TX_D_VLD) begin seen = 1'b1; break; end
        end
        check("tx_vld_seen", 32'(seen), 32'd1);
    endtask

    task automatic finish_cmd(input bit rnd_busy);
        wait_idle(rnd_busy);
        check("tx_count", 32'(tx_q.size() - tx_base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (tx_base + i < tx_q.size())
                check("tx_byte", 32'(tx_q[tx_base + i]), 32'(exp_q[i]));
        check("alu_en_count", 32'(en_cnt - en_base), 32'(exp_en));
        check("alu_a", 32'(bus.ALU_A), 32'(ma));
        check("alu_b", 32'(bus.ALU_B), 32'(mb));
        check("alu_fun", 32'(bus.ALU_FUN), 32'(mfun));
    endtask

    task automatic do_cmd(input bit is_op, input logic [7:0] a, input logic [7:0] b, input logic [7:0] f, input bit rnd_busy);
        begin_cmd();
        model_cmd(is_op, a, b, f);
        send_cmd(is_op, a, b, f);
        finish_cmd(rnd_busy);
    endtask

    function automatic logic [31:0] all_outs();
        return {bus.ALU_A, bus.ALU_B, bus.ALU_FUN, bus.ALU_EN,
                bus.TX_P_DATA, bus.TX_D_VLD, bus.CTRL_BUSY, bus.TIMEOUT_ERR};
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] rb;
        int sel;
        bus.RX_P_DATA = 8'h00;
        bus.RX_D_VLD  = 1'b0;
        bus.TX_BUSY   = 1'b0;
        #2 RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_outputs", all_outs(), 32'h0);
        RST = 1'b0;

        // ADD 0F+03 -> 12 00, first TX byte two cycles after ALU_EN
        do_cmd(1'b1, 8'h0F, 8'h03, 8'h00, 1'b0);
        check("t1_lo", 32'(tx_q[tx_base]), 32'h12);
        check("t1_latency", 32'(rise_cyc - en_cyc), 32'd2);

        // MUL with stored operands 15*3 -> 2D 00
        do_cmd(1'b0, 8'h00, 8'h00, 8'h02, 1'b0);
        check("t2_lo", 32'(tx_q[tx_base]), 32'h2D);
        check("t2_a_kept", 32'(bus.ALU_A), 32'h0F);

        // illegal function -> single EE, no ALU_EN
        do_cmd(1'b0, 8'h00, 8'h00, 8'h0F, 1'b0);
        check("t3_err", 32'(tx_q[tx_base]), 32'hEE);

        // stray byte in IDLE is ignored
        begin_cmd();
        send_byte(8'h55);
        @(negedge CLK);
        check("stray_busy", 32'(bus.CTRL_BUSY), 32'd0);
        repeat (5) @(negedge CLK);
        check("stray_busy_late", 32'(bus.CTRL_BUSY), 32'd0);
        finish_cmd(1'b0);

        // AND F0&0F = 0000 with TX held busy; a CC during the hold is dropped
        bus.TX_BUSY = 1'b1;
        begin_cmd();
        model_cmd(1'b1, 8'hF0, 8'h0F, 8'h04);
        send_cmd(1'b1, 8'hF0, 8'h0F, 8'h04);
        wait_tx_vld();
        send_byte(8'hCC);
        repeat (4) begin
            @(negedge CLK);
            check("busy_hold_vld", 32'(bus.TX_D_VLD), 32'd1);
            check("busy_hold_dat", 32'(bus.TX_P_DATA), 32'h00);
        end
        check("busy_no_xfer", 32'(tx_q.size() - tx_base), 32'd0);
        @(posedge CLK); #1;
        bus.TX_BUSY = 1'b0;
        finish_cmd(1'b0);
        repeat (4) @(negedge CLK);
        check("dropped_rx_idle", 32'(bus.CTRL_BUSY), 32'd0);

        // ALU never answers -> TIMEOUT_ERR 15 cycles after ALU_EN, nothing sent
        alu_vld_ena = 1'b0;
        begin_cmd();
        model_cmd(1'b1, 8'h01, 8'h01, 8'h00);
        exp_q.delete();
        send_cmd(1'b1, 8'h01, 8'h01, 8'h00);
        finish_cmd(1'b0);
        check("tmo_count", 32'(tmo_cnt - tmo_base), 32'd1);
        check("tmo_delay", 32'(tmo_cyc - en_cyc), 32'd15);
        alu_vld_ena = 1'b1;

        // reset while the high byte is waiting
        bus.TX_BUSY = 1'b1;
        begin_cmd();
        model_cmd(1'b1, 8'h12, 8'h34, 8'h00);
        send_cmd(1'b1, 8'h12, 8'h34, 8'h00);
        wait_tx_vld();
        @(posedge CLK); #1; bus.TX_BUSY = 1'b0;
        @(posedge CLK); #1; bus.TX_BUSY = 1'b1;
        @(negedge CLK);
        check("rst_lo_sent", 32'(tx_q.size() - tx_base), 32'd1);
        check("rst_lo_byte", 32'(tx_q[tx_base]), 32'h46);
        check("rst_hi_pending", 32'({bus.TX_D_VLD, bus.TX_P_DATA}), 32'h100);
        #1 RST = 1'b1;
        #1 check("rst_async", all_outs(), 32'h0);
        repeat (2) @(posedge CLK);
        #1;
        check("rst_no_tx", 32'(tx_q.size() - tx_base), 32'd1);
        RST = 1'b0;
        bus.TX_BUSY = 1'b0;
        ma = 8'h00; mb = 8'h00; mfun = 4'h0;
        do_cmd(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        check("post_rst_lo", 32'(tx_q[tx_base]), 32'h00);

        // random command traffic with random TX backpressure
        for (int n = 0; n < 24; n++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 3)
                do_cmd(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                       8'($urandom_range(0, 14)), 1'b1);
            else if (sel <= 6)
                do_cmd(1'b0, 8'h00, 8'h00, 8'($urandom_range(0, 14)), 1'b1);
            else if (sel == 7)
                do_cmd(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                       8'($urandom_range(0, 255)), 8'($urandom_range(15, 255)), 1'b1);
            else begin
                rb = 8'($urandom_range(0, 255));
                if (rb == CMD_ALU_OP || rb == CMD_ALU_NOP) rb = 8'h55;
                begin_cmd();
                send_byte(rb);
                repeat (3) @(negedge CLK);
                check("rnd_stray_busy", 32'(bus.CTRL_BUSY), 32'd0);
                finish_cmd(1'b0);
            end
            bus.TX_BUSY = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
